i2c_slave_regs: RTL and testbench
=================================

I2C_SLAVE_REGS -- requirements
Module: i2c_slave_regs

Interface
REQ-001 The block SHALL have parameter DEV_ADDR, default 7'h51, which is the 7-bit I2C target address it responds to.
REQ-002 clk  input  1  sole clock for all logic; frequency SHALL be at least 20x the SCL frequency.
REQ-003 rstn  input  1  reset, synchronous and active-high.
REQ-004 i2c_sclk  input  1  I2C clock from the bus master.
REQ-005 i2c_sdat  inout  1  I2C data line; driven 1'b0 when the block pulls low, otherwise 1'bz.
REQ-006 reg_addr  output  8  current register pointer.
REQ-007 reg_wr_en  output  1  one-cycle strobe: write reg_wr_data to reg_addr.
REQ-008 reg_wr_data  output  8  received data byte.
REQ-009 reg_rd_en  output  1  one-cycle strobe: user presents reg_rd_data for reg_addr in the same cycle.
REQ-010 reg_rd_data  input  8  register read data, combinational from reg_addr.
REQ-011 busy  output  1  high from an address-matched START until STOP or return to IDLE.

Function
REQ-012 SCL and SDA SHALL each pass through a 2-flop synchronizer plus one history flop; edges SHALL be detected 3 clk cycles after the pin transition.
REQ-013 A START SHALL be detected on synchronized SDA falling while SCL is high; a STOP on SDA rising while SCL is high.
REQ-014 Data SHALL be sampled on SCL rising edges, MSB first; i2c_sdat drive changes only on SCL falling edges.
REQ-015 States SHALL be IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
REQ-016 START from any state, including repeated START, SHALL clear the bit counter and go to DEV_ADDR.
REQ-017 STOP from any state SHALL go to IDLE, release i2c_sdat and clear busy.
REQ-018 DEV_ADDR: after 8 bits, if bits[7:1]==DEV_ADDR go to DEV_ACK, else go to IDLE without driving.
REQ-019 DEV_ACK: pull SDA low from the SCL falling edge after bit 8 to the SCL falling edge after bit 9.
REQ-020 After DEV_ACK, R/W=0 SHALL go to REG_ADDR; R/W=1 SHALL go to RD_DATA.
REQ-021 REG_ADDR: the 8 received bits SHALL load reg_addr; ACK via REG_ACK, then go to WR_DATA.
REQ-022 WR_DATA: after 8 bits, reg_wr_data SHALL be updated and reg_wr_en pulsed one cycle at the 8th SCL rising edge detection.
REQ-023 After the write byte, ACK via WR_ACK, increment reg_addr modulo 256 (8'hFF wraps to 8'h00), then return to WR_DATA.
REQ-024 On entry to RD_DATA, at the SCL falling edge, reg_rd_en SHALL pulse one cycle.
REQ-025 In the same cycle reg_rd_data SHALL be loaded into the TX shifter and reg_addr incremented modulo 256.
REQ-026 In RD_DATA, i2c_sdat SHALL be pulled low for 0 bits and released for 1 bits, with one bit per SCL falling edge.
REQ-027 RD_ACK: SDA SHALL be released and sampled at the 9th SCL rising edge; ACK (0) returns to RD_DATA for the next byte, NACK (1) goes to WAIT_STOP.
REQ-028 WAIT_STOP SHALL not drive SDA and SHALL wait for STOP or START.
REQ-029 Simultaneous SCL and SDA edges in one clk SHALL be treated as a data bit, not START/STOP.
REQ-030 A write transaction with only a register-address byte SHALL update reg_addr and produce no reg_wr_en.

Reset
REQ-031 While rstn=1, next clk: state=IDLE, i2c_sdat=z, reg_addr=8'h00, reg_wr_data=8'h00, reg_wr_en=0, reg_rd_en=0, busy=0, counters and shifters 0.
REQ-032 Synchronizer flops SHALL reset to 1 so that no false START or STOP is detected after reset.
REQ-033 Reset asserted mid-transaction SHALL abort immediately; the block SHALL ignore the bus until the next START.

Verification
REQ-034 Write 0xA2, 0x03, 0x45, STOP -> three ACKs; one reg_wr_en with reg_addr=0x03 and data 0x45; reg_addr=0x04 after.
REQ-035 Write 0xA2, 0x02; repeated START; 0xA3; read 3 bytes with ACK, ACK, NACK; STOP -> reg_rd_en at 0x02, 0x03, 0x04; bytes match reg_rd_data; reg_addr=0x05.
REQ-036 Address 0xA4 -> no ACK (SDA released at 9th clock), busy=0, no strobes.
REQ-037 Write 0xA2, 0xFF, 0x11, 0x22 -> writes at 0xFF then 0x00; pointer wraps.
REQ-038 Reset pulse during a data byte, then a fresh write 0xA2, 0x01, 0x7E -> SDA released, state IDLE; the fresh write completes normally.
REQ-039 START, STOP with no bits -> IDLE, no ACK, no strobes.

Source files
------------

// File: rtl/i2c_slave_regs.sv
// I2C target exposing an 8-bit register pointer; received bytes and read requests
// are handed to an external register file through one-cycle strobes.
module i2c_slave_regs #(
    parameter logic [6:0] DEV_ADDR = 7'h51
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       i2c_sclk,
    inout  wire        i2c_sdat,
    output logic [7:0] reg_addr,
    output logic       reg_wr_en,
    output logic [7:0] reg_wr_data,
    output logic       reg_rd_en,
    input  logic [7:0] reg_rd_data,
    output logic       busy
);

    typedef enum logic [3:0] {
        S_IDLE, S_DEV_ADDR, S_DEV_ACK, S_REG_ADDR, S_REG_ACK,
        S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_WAIT_STOP
    } state_t;

    logic       r_scl_s1, r_scl_s2, r_scl_d;
    logic       r_sda_s1, r_sda_s2, r_sda_d;
    state_t     r_state;
    logic [3:0] r_bit_cnt;
    logic [6:0] r_rx_sr;
    logic [6:0] r_tx_sr;
    logic [7:0] r_reg_addr;
    logic [7:0] r_wr_data;
    logic       r_wr_en, r_rd_en, r_busy, r_sda_oe, r_rw;

    logic       w_scl_rise, w_scl_fall, w_sda_rise, w_sda_fall;
    logic       w_start, w_stop, w_last_bit;
    logic [7:0] w_rx_byte;

    // Synchronizers idle high so that leaving reset never looks like a bus edge
    always_ff @(posedge clk) begin
        if (rstn) begin
            {r_scl_s1, r_scl_s2, r_scl_d} <= 3'b111;
            {r_sda_s1, r_sda_s2, r_sda_d} <= 3'b111;
        end else begin
            {r_scl_s1, r_scl_s2, r_scl_d} <= {i2c_sclk, r_scl_s1, r_scl_s2};
            {r_sda_s1, r_sda_s2, r_sda_d} <= {i2c_sdat, r_sda_s1, r_sda_s2};
        end
    end

    assign w_scl_rise = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall = ~r_scl_s2 & r_scl_d;
    assign w_sda_rise = r_sda_s2 & ~r_sda_d;
    assign w_sda_fall = ~r_sda_s2 & r_sda_d;
    // SCL must be stable high across the SDA edge; a same-cycle SCL edge makes it a data bit
    assign w_start    = w_sda_fall & r_scl_s2 & r_scl_d;
    assign w_stop     = w_sda_rise & r_scl_s2 & r_scl_d;
    assign w_last_bit = (r_bit_cnt == 4'd7);
    assign w_rx_byte  = {r_rx_sr, r_sda_s2};

    always_ff @(posedge clk) begin
        if (rstn) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= 4'd0;
            r_rx_sr    <= 7'd0;
            r_tx_sr    <= 7'd0;
            r_reg_addr <= 8'h00;
            r_wr_data  <= 8'h00;
            r_wr_en    <= 1'b0;
            r_rd_en    <= 1'b0;
            r_busy     <= 1'b0;
            r_sda_oe   <= 1'b0;
            r_rw       <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            r_rd_en <= 1'b0;
            if (w_start) begin
                r_state   <= S_DEV_ADDR;
                r_bit_cnt <= 4'd0;
                r_sda_oe  <= 1'b0;
            end else if (w_stop) begin
                r_state   <= S_IDLE;
                r_bit_cnt <= 4'd0;
                r_sda_oe  <= 1'b0;
                r_busy    <= 1'b0;
            end else begin
                case (r_state)
                    S_DEV_ADDR: if (w_scl_rise) begin
                        r_rx_sr   <= w_rx_byte[6:0];
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (w_last_bit) begin
                            r_bit_cnt <= 4'd0;
                            if (r_rx_sr == DEV_ADDR) begin
                                r_state <= S_DEV_ACK;
                                r_rw    <= r_sda_s2;
                                r_busy  <= 1'b1;
                            end else begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                    S_REG_ADDR: if (w_scl_rise) begin
                        r_rx_sr   <= w_rx_byte[6:0];
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (w_last_bit) begin
                            r_bit_cnt  <= 4'd0;
                            r_reg_addr <= w_rx_byte;
                            r_state    <= S_REG_ACK;
                        end
                    end
                    S_WR_DATA: if (w_scl_rise) begin
                        r_rx_sr   <= w_rx_byte[6:0];
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (w_last_bit) begin
                            r_bit_cnt <= 4'd0;
                            r_wr_data <= w_rx_byte;
                            r_wr_en   <= 1'b1;
                            r_state   <= S_WR_ACK;
                        end
                    end
                    // First SCL fall pulls SDA low, the second releases it and moves on
                    S_DEV_ACK, S_REG_ACK, S_WR_ACK: if (w_scl_fall) begin
                        r_sda_oe <= ~r_sda_oe;
                        if (r_sda_oe) begin
                            if (r_state == S_WR_ACK)
                                r_reg_addr <= r_reg_addr + 8'd1;
                            if (r_state == S_DEV_ACK && r_rw) begin
                                r_state <= S_RD_DATA;
                                r_rd_en <= 1'b1;
                            end else if (r_state == S_DEV_ACK) begin
                                r_state <= S_REG_ADDR;
                            end else begin
                                r_state <= S_WR_DATA;
                            end
                        end
                    end
                    // reg_rd_data is valid for the old pointer while the strobe is high
                    S_RD_DATA: begin
                        if (r_rd_en) begin
                            r_tx_sr    <= reg_rd_data[6:0];
                            r_sda_oe   <= ~reg_rd_data[7];
                            r_reg_addr <= r_reg_addr + 8'd1;
                        end else if (w_scl_fall) begin
                            r_tx_sr  <= {r_tx_sr[5:0], 1'b0};
                            r_sda_oe <= ~r_tx_sr[6];
                        end else if (w_scl_rise) begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (w_last_bit) begin
                                r_bit_cnt <= 4'd0;
                                r_state   <= S_RD_ACK;
                            end
                        end
                    end
                    S_RD_ACK: begin
                        if (w_scl_fall) begin
                            if (r_bit_cnt == 4'd0) begin
                                r_sda_oe <= 1'b0;
                            end else begin
                                r_bit_cnt <= 4'd0;
                                r_state   <= S_RD_DATA;
                                r_rd_en   <= 1'b1;
                            end
                        end else if (w_scl_rise) begin
                            if (r_sda_s2) r_state   <= S_WAIT_STOP;
                            else          r_bit_cnt <= 4'd1;
                        end
                    end
                    S_IDLE, S_WAIT_STOP: ;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign i2c_sdat    = r_sda_oe ? 1'b0 : 1'bz;
    assign reg_addr    = r_reg_addr;
    assign reg_wr_en   = r_wr_en;
    assign reg_wr_data = r_wr_data;
    assign reg_rd_en   = r_rd_en;
    assign busy        = r_busy;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench for i2c_slave_regs: a bit-banged bus master plus a register-file model
// that predicts write strobes, read bytes and the pointer after each transaction.
`timescale 1ns/1ps
module tb_i2c_slave_regs;

    localparam int         Q   = 80;
    localparam logic [6:0] DEV = 7'h51;

    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic       i2c_sclk = 1'b1;
    logic       m_drive_low = 1'b0;
    wire        i2c_sdat;
    logic [7:0] reg_addr, reg_wr_data, reg_rd_data;
    logic       reg_wr_en, reg_rd_en, busy;

    assign i2c_sdat = m_drive_low ? 1'b0 : 1'bz;
    pullup (i2c_sdat);

    i2c_slave_regs #(.DEV_ADDR(DEV)) dut (
        .clk(clk), .rstn(rstn), .i2c_sclk(i2c_sclk), .i2c_sdat(i2c_sdat),
        .reg_addr(reg_addr), .reg_wr_en(reg_wr_en), .reg_wr_data(reg_wr_data),
        .reg_rd_en(reg_rd_en), .reg_rd_data(reg_rd_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // User-side register file driven by the DUT strobes
    logic [7:0] init_mem [256];
    logic [7:0] umem [256];
    bit         written [256];
    assign reg_rd_data = written[reg_addr] ? umem[reg_addr] : init_mem[reg_addr];

    logic [7:0] wr_addr_q [$];
    logic [7:0] wr_data_q [$];
    logic [7:0] rd_addr_q [$];
    logic       busy_prev = 1'b0;
    int         busy_rises = 0;

    always @(negedge clk) begin
        if (reg_wr_en) begin
            umem[reg_addr]    <= reg_wr_data;
            written[reg_addr] <= 1'b1;
            wr_addr_q.push_back(reg_addr);
            wr_data_q.push_back(reg_wr_data);
        end
        if (reg_rd_en) rd_addr_q.push_back(reg_addr);
        busy_prev <= busy;
        if (busy && !busy_prev) busy_rises <= busy_rises + 1;
    end

    // Reference model: register contents and expected pointer
    logic [7:0] model_mem [256];
    logic [7:0] m_ptr;
    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_c();
        m_drive_low = 1'b0; #Q;
        i2c_sclk = 1'b1;    #Q;
        m_drive_low = 1'b1; #Q;
        i2c_sclk = 1'b0;    #Q;
    endtask

    task automatic stop_c();
        m_drive_low = 1'b1; #Q;
        i2c_sclk = 1'b1;    #Q;
        m_drive_low = 1'b0; #(2*Q);
    endtask

    task automatic clock_bit(input logic v);
        m_drive_low = ~v; #Q;
        i2c_sclk = 1'b1;  #(2*Q);
        i2c_sclk = 1'b0;  #Q;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked);
        for (int i = 7; i >= 0; i--) clock_bit(b[i]);
        m_drive_low = 1'b0; #Q;
        i2c_sclk = 1'b1;    #Q;
        acked = (i2c_sdat === 1'b0); #Q;
        i2c_sclk = 1'b0;    #Q;
    endtask

    task automatic recv_byte(input logic m_ack, output logic [7:0] b);
        m_drive_low = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            #Q; i2c_sclk = 1'b1;
            #Q; b[i] = (i2c_sdat !== 1'b0);
            #Q; i2c_sclk = 1'b0;
            #Q;
        end
        m_drive_low = m_ack; #Q;
        i2c_sclk = 1'b1;     #(2*Q);
        i2c_sclk = 1'b0;     #Q;
        m_drive_low = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] ptr, input logic [7:0] data [$], input string tag);
        logic ack;
        logic [7:0] a;
        int wb;
        wb = wr_addr_q.size();
        start_c();
        send_byte({DEV, 1'b0}, ack); check({tag, "_dev_ack"}, 32'(ack), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        send_byte(ptr, ack);         check({tag, "_ptr_ack"}, 32'(ack), 32'd1);
        foreach (data[i]) begin
            send_byte(data[i], ack); check({tag, "_data_ack"}, 32'(ack), 32'd1);
            a = ptr + 8'(i);
            model_mem[a] = data[i];
        end
        stop_c();
        check({tag, "_n_wr"}, 32'(wr_addr_q.size() - wb), 32'(data.size()));
        foreach (data[i]) begin
            if (wb + i < wr_addr_q.size()) begin
                a = ptr + 8'(i);
                check({tag, "_wr_addr"}, 32'(wr_addr_q[wb + i]), 32'(a));
                check({tag, "_wr_data"}, 32'(wr_data_q[wb + i]), 32'(data[i]));
            end
        end
        m_ptr = ptr + 8'(data.size());
        check({tag, "_ptr"}, 32'(reg_addr), 32'(m_ptr));
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    task automatic do_read(input logic [7:0] ptr, input int n, input string tag);
        logic ack;
        logic [7:0] a, b;
        int rb, wb;
        rb = rd_addr_q.size();
        wb = wr_addr_q.size();
        start_c();
        send_byte({DEV, 1'b0}, ack); check({tag, "_dev_ack_w"}, 32'(ack), 32'd1);
        send_byte(ptr, ack);         check({tag, "_ptr_ack"}, 32'(ack), 32'd1);
        start_c();
        send_byte({DEV, 1'b1}, ack); check({tag, "_dev_ack_r"}, 32'(ack), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        for (int i = 0; i < n; i++) begin
            recv_byte(i < n - 1, b);
            a = ptr + 8'(i);
            check({tag, "_rdata"}, 32'(b), 32'(model_mem[a]));
        end
        stop_c();
        check({tag, "_n_rd"}, 32'(rd_addr_q.size() - rb), 32'(n));
        check({tag, "_n_wr"}, 32'(wr_addr_q.size() - wb), 32'd0);
        for (int i = 0; i < n; i++) begin
            if (rb + i < rd_addr_q.size()) begin
                a = ptr + 8'(i);
                check({tag, "_rd_addr"}, 32'(rd_addr_q[rb + i]), 32'(a));
            end
        end
        m_ptr = ptr + 8'(n);
        check({tag, "_ptr"}, 32'(reg_addr), 32'(m_ptr));
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        logic [7:0] q [$];
        logic       ack;
        int         wb, rb, br;
        logic [7:0] p;
        int         n;

        for (int i = 0; i < 256; i++) begin
            init_mem[i]  = 8'($urandom);
            model_mem[i] = init_mem[i];
        end
        m_ptr = 8'h00;

        repeat (4) @(negedge clk);
        check("rst_addr",    32'(reg_addr),    32'h00);
        check("rst_wr_data", 32'(reg_wr_data), 32'h00);
        check("rst_wr_en",   32'(reg_wr_en),   32'd0);
        check("rst_rd_en",   32'(reg_rd_en),   32'd0);
        check("rst_busy",    32'(busy),        32'd0);
        check("rst_sda",     32'(i2c_sdat !== 1'b0), 32'd1);
        rstn = 1'b0;
        repeat (4) @(negedge clk);

        q = '{8'h45};
        do_write(8'h03, q, "wr_basic");

        do_read(8'h02, 3, "rd_basic");

        wb = wr_addr_q.size(); rb = rd_addr_q.size(); br = busy_rises;
        start_c();
        send_byte(8'hA4, ack);
        check("bad_addr_ack", 32'(ack), 32'd0);
        check("bad_addr_busy", 32'(busy), 32'd0);
        stop_c();
        check("bad_addr_strobes", 32'((wr_addr_q.size() - wb) + (rd_addr_q.size() - rb)), 32'd0);
        check("bad_addr_busy_rise", 32'(busy_rises - br), 32'd0);
        check("bad_addr_ptr", 32'(reg_addr), 32'(m_ptr));

        q = '{8'h11, 8'h22};
        do_write(8'hFF, q, "wr_wrap");

        q = {};
        do_write(8'h5A, q, "wr_ptr_only");

        wb = wr_addr_q.size(); rb = rd_addr_q.size(); br = busy_rises;
        start_c();
        stop_c();
        check("start_stop_strobes", 32'((wr_addr_q.size() - wb) + (rd_addr_q.size() - rb)), 32'd0);
        check("start_stop_busy", 32'(busy_rises - br), 32'd0);
        check("start_stop_sda", 32'(i2c_sdat !== 1'b0), 32'd1);
        check("start_stop_ptr", 32'(reg_addr), 32'(m_ptr));

        wb = wr_addr_q.size();
        start_c();
        send_byte({DEV, 1'b0}, ack); check("rst_mid_dev_ack", 32'(ack), 32'd1);
        send_byte(8'h10, ack);       check("rst_mid_ptr_ack", 32'(ack), 32'd1);
        for (int i = 0; i < 4; i++) clock_bit(1'($urandom));
        @(negedge clk); rstn = 1'b1;
        repeat (2) @(negedge clk); rstn = 1'b0;
        m_drive_low = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_mid_sda", 32'(i2c_sdat !== 1'b0), 32'd1);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_ptr", 32'(reg_addr), 32'h00);
        for (int i = 0; i < 4; i++) clock_bit(1'($urandom));
        m_drive_low = 1'b0; #Q;
        i2c_sclk = 1'b1;    #Q;
        check("rst_mid_no_ack", 32'(i2c_sdat !== 1'b0), 32'd1);
        #Q; i2c_sclk = 1'b0; #Q;
        check("rst_mid_no_wr", 32'(wr_addr_q.size() - wb), 32'd0);
        q = '{8'h7E};
        do_write(8'h01, q, "wr_after_rst");

        for (int k = 0; k < 6; k++) begin
            p = 8'($urandom);
            n = $urandom_range(1, 4);
            if ($urandom_range(0, 1) == 1) begin
                q = {};
                for (int i = 0; i < n; i++) q.push_back(8'($urandom));
                do_write(p, q, "rand_wr");
            end else begin
                do_read(p, n, "rand_rd");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
